// File: rtl/lsu_pkg.sv
// Shared types and helpers for the pipelined MIPS load/store unit.
package lsu_pkg;

   typedef enum logic [3:0] {
      OP_LB  = 4'd0,
      OP_LBU = 4'd1,
      OP_LH  = 4'd2,
      OP_LHU = 4'd3,
      OP_LW  = 4'd4,
      OP_SB  = 4'd5,
      OP_SH  = 4'd6,
      OP_SW  = 4'd7
   } lsu_op_t;

   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;

   // Widest destination-register index the tracking queue can carry.
   // REG_ADDR_W of lsu_pipe must not exceed this.
   localparam int WD_MAX_W = 8;

   typedef struct packed {
      lsu_op_t             op;
      logic [WD_MAX_W-1:0] wd;
      logic [1:0]          off;       // byte offset, selects the load lane
      logic [31:0]         pc;
      logic                is_store;
      logic                squash;    // set by flush: drop the writeback
   } lsu_entry_t;

   function automatic logic op_is_store(input lsu_op_t op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

   // Bus size code: 0 = byte, 1 = half, 2 = word.
   function automatic logic [1:0] op_size(input lsu_op_t op);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 2'd0;
         OP_LH, OP_LHU, OP_SH: return 2'd1;
         default:              return 2'd2;
      endcase
   endfunction

   function automatic logic op_misaligned(input lsu_op_t op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return a[0];
         OP_LW, OP_SW:         return |a;
         default:              return 1'b0;
      endcase
   endfunction

   // Replicate the store operand across every lane it could land in.
   function automatic logic [31:0] store_lanes(input lsu_op_t op, input logic [31:0] d);
      case (op)
         OP_SB:   return {4{d[7:0]}};
         OP_SH:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Pick the addressed lane out of the returned word and extend it.
   function automatic logic [31:0] load_extract(input lsu_op_t op, input logic [1:0] off,
                                                input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'h0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'h0, h};
         default: return rdata;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline request, data bus, writeback and exception signals of the LSU.
// slave: the LSU itself. master: the surrounding pipeline and memory.
interface lsu_if #(parameter int REG_ADDR_W = 5);
   import lsu_pkg::*;

   logic                  req_valid;
   logic                  req_ready;
   lsu_op_t               req_op;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   logic [REG_ADDR_W-1:0] req_wd;
   logic [31:0]           req_pc;
   logic                  flush;

   logic                  data_req;
   logic                  data_wr;
   logic [1:0]            data_size;
   logic [31:0]           data_addr;
   logic [31:0]           data_wdata;
   logic [31:0]           data_rdata;
   logic                  data_addr_ok;
   logic                  data_data_ok;

   logic                  wb_valid;
   logic [REG_ADDR_W-1:0] wb_wd;
   logic [31:0]           wb_data;
   logic [31:0]           wb_pc;

   logic                  exc_valid;
   logic [4:0]            exc_code;
   logic [31:0]           exc_badvaddr;
   logic [31:0]           exc_pc;

   logic                  busy;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, req_wd, req_pc, flush,
      input  data_rdata, data_addr_ok, data_data_ok,
      output req_ready, data_req, data_wr, data_size, data_addr, data_wdata,
      output wb_valid, wb_wd, wb_data, wb_pc,
      output exc_valid, exc_code, exc_badvaddr, exc_pc, busy
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, req_wd, req_pc, flush,
      output data_rdata, data_addr_ok, data_data_ok,
      input  req_ready, data_req, data_wr, data_size, data_addr, data_wdata,
      input  wb_valid, wb_wd, wb_data, wb_pc,
      input  exc_valid, exc_code, exc_badvaddr, exc_pc, busy
   );

endinterface

// File: rtl/lsu_fifo.sv
// Tracking queue of outstanding bus transactions, oldest at the head.
// squash_all marks every queued entry so its load result is discarded.
module lsu_fifo
   import lsu_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  lsu_entry_t       push_entry,
   input  logic             pop,
   input  logic             squash_all,
   output lsu_entry_t       head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   lsu_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Entry storage; squash is set on all slots, harmless for empty ones
   // because a push overwrites the whole entry.
   // NOTE: storage has no reset; count and pointers alone define validity.
   always_ff @(posedge clk) begin
      if (squash_all) begin
         for (int i = 0; i < DEPTH; i++) mem[i].squash <= 1'b1;
      end
      if (do_push) mem[wr_ptr] <= push_entry;
   end

   // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
   // NOTE: non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= next_ptr(wr_ptr);
         if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/lsu_pipe.sv
// MEM-stage load/store unit with up to DEPTH bus transactions in flight.
// Misaligned ops raise AdEL/AdES without touching the bus; loads return an
// aligned, extended result one cycle after data_ok.
module lsu_pipe
   import lsu_pkg::*;
#(
   parameter int DEPTH      = 2,
   parameter int REG_ADDR_W = 5
) (
   input logic clk,
   input logic rst,
   lsu_if.slave bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   logic             misaligned;
   logic             full;
   logic             empty;
   logic             fire;
   logic             pop;
   logic             wb_fire;
   logic             exc_fire;
   lsu_entry_t       push_entry;
   lsu_entry_t       head;
   logic [CNT_W-1:0] unused_count;
   logic             unused_wd;

   assign misaligned = op_misaligned(bus.req_op, bus.req_addr[1:0]);

   // Bus side is purely combinational from the held request.
   assign bus.data_req   = bus.req_valid && !misaligned && !full && !bus.flush;
   assign bus.data_wr    = op_is_store(bus.req_op);
   assign bus.data_size  = op_size(bus.req_op);
   assign bus.data_addr  = bus.req_addr;
   assign bus.data_wdata = store_lanes(bus.req_op, bus.req_wdata);

   assign fire          = bus.data_req && bus.data_addr_ok;
   assign bus.req_ready = bus.req_valid && (bus.flush || misaligned || fire);
   assign pop           = bus.data_data_ok && !empty;
   assign bus.busy      = !empty;

   // A flushed head never writes back, even when its data arrives with the flush.
   assign wb_fire = pop && !head.is_store && !head.squash && !bus.flush;

   // A flushed instruction is discarded, so it cannot fault either.
   assign exc_fire = bus.req_valid && misaligned && !bus.flush;

   // Tracking record for the op being issued this cycle.
   // NOTE: every field assigned on every pass, so no latch is inferred.
   always_comb begin
      push_entry          = '0;
      push_entry.op       = bus.req_op;
      push_entry.wd       = WD_MAX_W'(bus.req_wd);
      push_entry.off      = bus.req_addr[1:0];
      push_entry.pc       = bus.req_pc;
      push_entry.is_store = op_is_store(bus.req_op);
      push_entry.squash   = 1'b0;
   end

   lsu_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (fire),
      .push_entry (push_entry),
      .pop        (pop),
      .squash_all (bus.flush),
      .head       (head),
      .full       (full),
      .empty      (empty),
      .count      (unused_count)
   );

   // Only the low REG_ADDR_W bits of the stored destination are meaningful.
   assign unused_wd = ^head.wd;

   // Registered load writeback; payload holds its last value between pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.wb_valid <= 1'b0;
         bus.wb_wd    <= '0;
         bus.wb_data  <= '0;
         bus.wb_pc    <= '0;
      end else begin
         bus.wb_valid <= wb_fire;
         if (wb_fire) begin
            bus.wb_wd   <= head.wd[REG_ADDR_W-1:0];
            bus.wb_data <= load_extract(head.op, head.off, bus.data_rdata);
            bus.wb_pc   <= head.pc;
         end
      end
   end

   // Registered address-error report for misaligned requests.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.exc_valid    <= 1'b0;
         bus.exc_code     <= '0;
         bus.exc_badvaddr <= '0;
         bus.exc_pc       <= '0;
      end else begin
         bus.exc_valid <= exc_fire;
         if (exc_fire) begin
            bus.exc_code     <= op_is_store(bus.req_op) ? EXC_ADES : EXC_ADEL;
            bus.exc_badvaddr <= bus.req_addr;
            bus.exc_pc       <= bus.req_pc;
         end
      end
   end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe (DEPTH=2) with a scoreboard of issued ops.
module tb_lsu_pipe;
   import lsu_pkg::*;

   logic clk;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   lsu_if #(.REG_ADDR_W(5)) bus ();

   lsu_pipe #(.DEPTH(2), .REG_ADDR_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      lsu_op_t     op;
      logic [4:0]  wd;
      logic [31:0] addr;
      logic [31:0] pc;
      logic        squash;
   } sb_t;

   sb_t sb [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic tb_is_load(input lsu_op_t op);
      return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
   endfunction

   // Independent model: shift the addressed lane down, then extend.
   function automatic logic [31:0] tb_extract(input lsu_op_t op, input logic [31:0] addr,
                                              input logic [31:0] rdata);
      logic [31:0] s;
      s = rdata >> {addr[1:0], 3'b000};
      case (op)
         OP_LB:   return {{24{s[7]}}, s[7:0]};
         OP_LBU:  return {24'h0, s[7:0]};
         OP_LH:   return {{16{s[15]}}, s[15:0]};
         OP_LHU:  return {16'h0, s[15:0]};
         default: return rdata;
      endcase
   endfunction

   task automatic drive(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wd, input logic [31:0] pc);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      bus.req_wd    = wd;
      bus.req_pc    = pc;
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
   endtask

   // Offer an aligned op with addr_ok high; it must fire this cycle.
   task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] wd, input logic [31:0] pc);
      drive(op, addr, wdata, wd, pc);
      #1;
      check("issue_data_req", bus.data_req, 1'b1);
      check("issue_req_ready", bus.req_ready, 1'b1);
      sb.push_back('{op: op, wd: wd, addr: addr, pc: pc, squash: 1'b0});
      tick();
      idle();
   endtask

   // Return data for the oldest op, optionally with a flush in the same cycle.
   task automatic respond(input logic [31:0] rdata, input logic with_flush);
      sb_t         e;
      logic        exp_wb;
      logic [31:0] exp_data;
      bus.data_data_ok = 1'b1;
      bus.data_rdata   = rdata;
      bus.flush        = with_flush;
      if (with_flush) foreach (sb[i]) sb[i].squash = 1'b1;
      exp_wb   = 1'b0;
      exp_data = '0;
      if (sb.size() > 0) begin
         e        = sb.pop_front();
         exp_wb   = tb_is_load(e.op) && !e.squash;
         exp_data = tb_extract(e.op, e.addr, rdata);
      end
      tick();
      bus.data_data_ok = 1'b0;
      bus.flush        = 1'b0;
      check("wb_valid", bus.wb_valid, exp_wb);
      if (exp_wb) begin
         check("wb_data", bus.wb_data, exp_data);
         check("wb_wd", bus.wb_wd, e.wd);
         check("wb_pc", bus.wb_pc, e.pc);
      end
   endtask

   task automatic misaligned(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] pc,
                             input logic [4:0] code);
      drive(op, addr, 32'h0, 5'd1, pc);
      #1;
      check("mis_data_req", bus.data_req, 1'b0);
      check("mis_req_ready", bus.req_ready, 1'b1);
      tick();
      idle();
      check("exc_valid", bus.exc_valid, 1'b1);
      check("exc_code", bus.exc_code, code);
      check("exc_badvaddr", bus.exc_badvaddr, addr);
      check("exc_pc", bus.exc_pc, pc);
      tick();
      check("exc_pulse", bus.exc_valid, 1'b0);
   endtask

   initial begin
      rst              = 1'b1;
      bus.req_valid    = 1'b0;
      bus.req_op       = OP_LW;
      bus.req_addr     = '0;
      bus.req_wdata    = '0;
      bus.req_wd       = '0;
      bus.req_pc       = '0;
      bus.flush        = 1'b0;
      bus.data_rdata   = '0;
      bus.data_addr_ok = 1'b1;
      bus.data_data_ok = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_wb_valid", bus.wb_valid, 1'b0);
      check("rst_exc_valid", bus.exc_valid, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_wb_data", bus.wb_data, 32'h0);
      check("rst_exc_code", bus.exc_code, 5'd0);
      check("rst_data_req", bus.data_req, 1'b0);
      rst = 1'b0;
      tick();

      // LW with data_ok two cycles after issue
      issue(OP_LW, 32'h100, 32'h0, 5'd3, 32'h400);
      check("lw_busy", bus.busy, 1'b1);
      tick();
      respond(32'hDEADBEEF, 1'b0);
      check("lw_value", bus.wb_data, 32'hDEADBEEF);
      tick();
      check("wb_pulse", bus.wb_valid, 1'b0);
      check("lw_idle", bus.busy, 1'b0);

      // Lane selection and extension
      issue(OP_LB, 32'h103, 32'h0, 5'd4, 32'h404);
      respond(32'h80112233, 1'b0);
      check("lb_sext", bus.wb_data, 32'hFFFFFF80);
      issue(OP_LBU, 32'h103, 32'h0, 5'd5, 32'h408);
      respond(32'h80112233, 1'b0);
      check("lbu_zext", bus.wb_data, 32'h00000080);
      issue(OP_LH, 32'h102, 32'h0, 5'd6, 32'h40C);
      respond(32'h80112233, 1'b0);
      check("lh_sext", bus.wb_data, 32'hFFFF8011);
      issue(OP_LHU, 32'h100, 32'h0, 5'd7, 32'h410);
      respond(32'h8011A233, 1'b0);
      check("lhu_zext", bus.wb_data, 32'h0000A233);
      issue(OP_LB, 32'h101, 32'h0, 5'd8, 32'h414);
      respond(32'h80112233, 1'b0);

      // Queue full: third load held until the first data_ok
      issue(OP_LW, 32'h200, 32'h0, 5'd10, 32'h500);
      issue(OP_LW, 32'h204, 32'h0, 5'd11, 32'h504);
      drive(OP_LW, 32'h208, 32'h0, 5'd12, 32'h508);
      #1;
      check("full_data_req", bus.data_req, 1'b0);
      check("full_req_ready", bus.req_ready, 1'b0);
      tick();
      check("full_hold", bus.data_req, 1'b0);
      respond(32'hAAAA0001, 1'b0);
      check("after_pop_data_req", bus.data_req, 1'b1);
      check("after_pop_req_ready", bus.req_ready, 1'b1);
      sb.push_back('{op: OP_LW, wd: 5'd12, addr: 32'h208, pc: 32'h508, squash: 1'b0});
      tick();
      idle();
      respond(32'hAAAA0002, 1'b0);
      respond(32'hAAAA0003, 1'b0);
      check("order_last", bus.wb_data, 32'hAAAA0003);

      // Address errors
      misaligned(OP_SW, 32'h101, 32'h600, EXC_ADES);
      misaligned(OP_LH, 32'h001, 32'h604, EXC_ADEL);
      misaligned(OP_LW, 32'h102, 32'h608, EXC_ADEL);

      // Flush squashes both in-flight loads
      issue(OP_LW, 32'h300, 32'h0, 5'd13, 32'h700);
      issue(OP_LW, 32'h304, 32'h0, 5'd14, 32'h704);
      bus.flush = 1'b1;
      foreach (sb[i]) sb[i].squash = 1'b1;
      tick();
      bus.flush = 1'b0;
      respond(32'h11111111, 1'b0);
      check("flush_busy_mid", bus.busy, 1'b1);
      respond(32'h22222222, 1'b0);
      check("flush_busy_end", bus.busy, 1'b0);

      // Flush coinciding with data_ok
      issue(OP_LW, 32'h310, 32'h0, 5'd15, 32'h710);
      respond(32'h33333333, 1'b1);
      check("flush_ok_busy", bus.busy, 1'b0);

      // Byte and half stores: lane replication, silent pop
      drive(OP_SB, 32'h10, 32'h12345678, 5'd0, 32'h800);
      #1;
      check("sb_wdata", bus.data_wdata, 32'h78787878);
      check("sb_size", bus.data_size, 2'd0);
      check("sb_wr", bus.data_wr, 1'b1);
      issue(OP_SB, 32'h10, 32'h12345678, 5'd0, 32'h800);
      respond(32'h0, 1'b0);
      drive(OP_SH, 32'h12, 32'h12345678, 5'd0, 32'h804);
      #1;
      check("sh_wdata", bus.data_wdata, 32'h56785678);
      check("sh_size", bus.data_size, 2'd1);
      issue(OP_SH, 32'h12, 32'h12345678, 5'd0, 32'h804);
      respond(32'h0, 1'b0);

      // data_ok with an empty queue is ignored
      respond(32'h44444444, 1'b0);
      check("empty_ok_busy", bus.busy, 1'b0);

      // Reset mid-transaction drops the entry; late data_ok ignored
      issue(OP_LW, 32'h400, 32'h0, 5'd16, 32'h900);
      rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 1'b0);
      rst = 1'b0;
      sb.delete();
      tick();
      respond(32'h55555555, 1'b0);
      check("late_ok_busy", bus.busy, 1'b0);

      // Queue still works after all of the above
      issue(OP_LBU, 32'h402, 32'h0, 5'd17, 32'h904);
      respond(32'h00C30000, 1'b0);
      check("final_lbu", bus.wb_data, 32'h000000C3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
